// File: rtl/spdif_pkg.sv
// Shared types for the S/PDIF sample path: state encoding, sample pair layout and
// counter width.
package spdif_pkg;
  localparam int SAMPLE_W = 16;
  localparam int UCNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_MUTE  = 2'd3
  } state_e;

  // Stored as {r,l} so a FIFO entry is one 32-bit word.
  typedef struct packed {
    logic [SAMPLE_W-1:0] r;
    logic [SAMPLE_W-1:0] l;
  } pair_t;
endpackage

// File: rtl/spdif_sample_fifo.sv
// Synchronous FIFO of stereo pairs. The head entry is shown combinationally and
// the level carries one extra bit so that full and empty are distinct.
module spdif_sample_fifo
  import spdif_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  pair_t                  din,
  output pair_t                  dout,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  pair_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign dout = mem[rd_ptr];
endmodule

// File: rtl/spdif_sample_ctrl.sv
// Sample scheduler: buffers producer pairs, primes, then releases one pair per
// transmitter request; mutes and re-primes on underrun.
module spdif_sample_ctrl
  import spdif_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PRIME = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [SAMPLE_W-1:0]    in_l_i,
  input  logic [SAMPLE_W-1:0]    in_r_i,
  input  logic                   sample_req_i,
  output logic [SAMPLE_W-1:0]    audio_l_o,
  output logic [SAMPLE_W-1:0]    audio_r_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic [UCNT_W-1:0]      underrun_cnt_o,
  output logic [1:0]             state_o
);
  localparam int LW = $clog2(DEPTH) + 1;

  state_e          state;
  pair_t           aud, head, din;
  logic [LW-1:0]   level;
  logic            empty, push, pop;

  assign empty      = (level == '0);
  // Ready depends only on registered state, so producers see no comb path.
  assign in_ready_o = (state != ST_IDLE) && (level < LW'(DEPTH));
  assign push       = in_valid_i && in_ready_o;
  assign pop        = enable_i && (state == ST_RUN) && sample_req_i && !empty;
  assign din        = '{r: in_r_i, l: in_l_i};

  spdif_sample_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (!enable_i),
    .din   (din),
    .dout  (head),
    .level (level)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      aud            <= '0;
      underrun_cnt_o <= '0;
    end else if (!enable_i) begin
      state <= ST_IDLE;
      aud   <= '0;
    end else begin
      case (state)
        ST_IDLE:  state <= ST_PRIME;
        ST_PRIME: if (level >= LW'(PRIME)) state <= ST_RUN;
        ST_RUN: begin
          if (sample_req_i) begin
            if (!empty) begin
              aud <= head;
            end else begin
              // Underrun: output silence rather than repeating the last pair.
              aud   <= '0;
              state <= ST_MUTE;
              if (underrun_cnt_o != '1) underrun_cnt_o <= underrun_cnt_o + 1'b1;
            end
          end
        end
        ST_MUTE:  state <= ST_PRIME;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign audio_l_o = aud.l;
  assign audio_r_o = aud.r;
  assign level_o   = level;
  assign state_o   = state;
endmodule

// File: tb/tb_spdif_sample_ctrl.sv
// Scoreboard bench: driver updates a queue-based reference model and queues
// expected audio; a negedge monitor pops and compares.
module tb_spdif_sample_ctrl;
  localparam int DEPTH = 4;
  localparam int PRIME = 2;

  logic        clk = 1'b0;
  logic        rst_i, enable_i, in_valid_i, sample_req_i;
  logic [15:0] in_l_i, in_r_i;
  logic        in_ready_o;
  logic [15:0] audio_l_o, audio_r_o;
  logic [2:0]  level_o;
  logic [7:0]  underrun_cnt_o;
  logic [1:0]  state_o;

  spdif_sample_ctrl #(.DEPTH(DEPTH), .PRIME(PRIME)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_l_i(in_l_i), .in_r_i(in_r_i), .sample_req_i(sample_req_i),
    .audio_l_o(audio_l_o), .audio_r_o(audio_r_o), .level_o(level_o),
    .underrun_cnt_o(underrun_cnt_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 1'b0;
  logic [31:0] exp_q[$];

  // Reference model: phase 0..3 as seen on state_o, FIFO as a queue of {r,l}.
  int          m_phase = 0;
  logic [31:0] m_fifo[$];
  int          m_cnt = 0;
  logic [31:0] m_aud = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return (m_phase != 0) && (m_fifo.size() < DEPTH);
  endfunction

  task automatic model_update(input bit rs, input bit en, input bit v,
                              input logic [15:0] l, input logic [15:0] r, input bit req);
    bit rdy;
    int n0;
    rdy = m_ready();
    n0  = m_fifo.size();
    if (rs || !en) begin
      m_phase = 0;
      m_fifo.delete();
      if (rs) m_cnt = 0;
      m_aud = '0;
      exp_q.push_back(m_aud);
    end else begin
      case (m_phase)
        0: m_phase = 1;
        1: if (n0 >= PRIME) m_phase = 2;
        2: if (req) begin
             if (n0 > 0) m_aud = m_fifo.pop_front();
             else begin
               m_aud = '0;
               if (m_cnt < 255) m_cnt++;
               m_phase = 3;
             end
             exp_q.push_back(m_aud);
           end
        default: m_phase = 1;
      endcase
      if (v && rdy) m_fifo.push_back({r, l});
    end
  endtask

  task automatic step(input bit rs, input bit en, input bit v,
                      input logic [15:0] l, input logic [15:0] r, input bit req);
    rst_i = rs; enable_i = en; in_valid_i = v; in_l_i = l; in_r_i = r; sample_req_i = req;
    @(posedge clk);
    #1;
    model_update(rs, en, v, l, r, req);
  endtask

  task automatic idle();                       step(0, 1, 0, 16'h0, 16'h0, 0); endtask
  task automatic push(input logic [15:0] l, r); step(0, 1, 1, l, r, 0);         endtask
  task automatic req();                        step(0, 1, 0, 16'h0, 16'h0, 1); endtask

  // Monitor: compares every cycle; audio events come from the expected queue.
  initial begin
    logic [31:0] held;
    held = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() > 0) held = exp_q.pop_front();
        chk("audio", {audio_r_o, audio_l_o}, held);
        chk("state", 32'(state_o), m_phase);
        chk("level", 32'(level_o), m_fifo.size());
        chk("ready", 32'(in_ready_o), 32'(m_ready()));
        chk("ucnt", 32'(underrun_cnt_o), m_cnt);
      end
    end
  end

  initial begin
    step(1, 0, 0, 16'h0, 16'h0, 0);
    mon_en = 1'b1;
    step(1, 0, 0, 16'h0, 16'h0, 0);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_ready", 32'(in_ready_o), 0);

    // Prime with two pairs, then first request.
    idle();
    push(16'h1111, 16'h2222);
    push(16'h3333, 16'h4444);
    idle();
    chk("prime_run", 32'(state_o), 2);
    chk("prime_lvl", 32'(level_o), 2);
    req();
    chk("first_pop", {audio_r_o, audio_l_o}, 32'h2222_1111);
    chk("first_lvl", 32'(level_o), 1);

    // Fill to DEPTH with no requests.
    for (int i = 0; i < 6; i++) push(16'(16'hA000 + i), 16'(16'hB000 + i));
    chk("full_lvl", 32'(level_o), DEPTH);
    chk("full_rdy", 32'(in_ready_o), 0);
    req();
    chk("full_pop", {audio_r_o, audio_l_o}, 32'h4444_3333);
    chk("full_rdy1", 32'(in_ready_o), 1);

    // Drain and underrun.
    repeat (3) req();
    req();
    chk("ur_audio", {audio_r_o, audio_l_o}, 32'h0);
    chk("ur_cnt", 32'(underrun_cnt_o), 1);
    chk("ur_mute", 32'(state_o), 3);
    idle();
    chk("ur_prime", 32'(state_o), 1);

    // Push coinciding with an underrun request.
    push(16'h0001, 16'h0002);
    push(16'h0003, 16'h0004);
    idle();
    req();
    req();
    step(0, 1, 1, 16'hAAAA, 16'h5555, 1);
    chk("pu_cnt", 32'(underrun_cnt_o), 2);
    chk("pu_lvl", 32'(level_o), 1);
    idle();
    push(16'h0005, 16'h0006);
    idle();
    req();
    chk("pu_pop", {audio_r_o, audio_l_o}, 32'h5555_AAAA);

    // Disable with level 3.
    push(16'h0007, 16'h0008);
    push(16'h0009, 16'h000A);
    chk("dis_pre", 32'(level_o), 3);
    step(0, 0, 0, 16'h0, 16'h0, 0);
    chk("dis_state", 32'(state_o), 0);
    chk("dis_lvl", 32'(level_o), 0);
    chk("dis_cnt", 32'(underrun_cnt_o), 2);
    idle();
    chk("reen_prime", 32'(state_o), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 499) == 0, $urandom_range(0, 39) != 0,
           $urandom_range(0, 9) < 6, 16'($urandom), 16'($urandom),
           $urandom_range(0, 9) < 3);

    // Counter saturation.
    step(1, 0, 0, 16'h0, 16'h0, 0);
    idle();
    for (int i = 0; i < 300; i++) begin
      push(16'($urandom), 16'($urandom));
      push(16'($urandom), 16'($urandom));
      idle();
      req();
      req();
      req();
      idle();
    end
    chk("sat_cnt", 32'(underrun_cnt_o), 255);

    // Reset mid-RUN.
    push(16'h1234, 16'h5678);
    push(16'h9ABC, 16'hDEF0);
    idle();
    req();
    chk("mid_run", 32'(state_o), 2);
    step(1, 1, 0, 16'h0, 16'h0, 0);
    chk("mrst_state", 32'(state_o), 0);
    chk("mrst_lvl", 32'(level_o), 0);
    chk("mrst_rdy", 32'(in_ready_o), 0);
    chk("mrst_cnt", 32'(underrun_cnt_o), 0);
    chk("mrst_aud", {audio_r_o, audio_l_o}, 32'h0);

    idle();
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
